regwrite_scoreboard: RTL and testbench

- Issue-control scoreboard for the two-slot VLIW bundle: one ALU slot and one MEM slot, both writing the shared 8x32 register file.
- Tracks in-flight register writes per register with countdown timers.
- Stalls decode on RAW/WAW hazards against in-flight writes.
- Splits a bundle whose two slots target the same rd: ALU slot issues first, MEM slot later, so the final value is the MEM result.
- Sits between decode (control signals, register indices) and the ID/EX pipeline register.

---
 rtl/regwrite_scoreboard_if.sv | 37 +++
 rtl/regwrite_scoreboard.sv | 103 ++++++++++
 tb/tb_regwrite_scoreboard.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/regwrite_scoreboard_if.sv
// Decode <-> scoreboard bundle interface: per-slot control/indices in, issue/stall status out.
`timescale 1ns/1ps
interface regwrite_scoreboard_if;
   localparam int unsigned REG_AW = 3;
   localparam int unsigned NREG   = 8;

   logic              bundle_valid;
   logic              flush;
   logic              alu_regWrite;
   logic              alu_useRm;
   logic [REG_AW-1:0] alu_rm;
   logic [REG_AW-1:0] alu_rn;
   logic [REG_AW-1:0] alu_rd;
   logic              mem_regWrite;
   logic              mem_useRd;
   logic [REG_AW-1:0] mem_rn;
   logic [REG_AW-1:0] mem_rd;
   logic              alu_issue;
   logic              mem_issue;
   logic              stall;
   logic              split_active;
   logic [NREG-1:0]   busy_mask;

   modport master (
      output bundle_valid, flush,
      output alu_regWrite, alu_useRm, alu_rm, alu_rn, alu_rd,
      output mem_regWrite, mem_useRd, mem_rn, mem_rd,
      input  alu_issue, mem_issue, stall, split_active, busy_mask
   );

   modport slave (
      input  bundle_valid, flush,
      input  alu_regWrite, alu_useRm, alu_rm, alu_rn, alu_rd,
      input  mem_regWrite, mem_useRd, mem_rn, mem_rd,
      output alu_issue, mem_issue, stall, split_active, busy_mask
   );
endinterface

// File: rtl/regwrite_scoreboard.sv
// Two-slot (ALU + MEM) issue scoreboard with per-register write countdowns and same-rd bundle splitting.
// Optional SCOREBOARD_EARLY_RELEASE_EN: a register in its last countdown cycle counts as ready.
`timescale 1ns/1ps
module regwrite_scoreboard #(
   parameter int unsigned ALU_LAT = 2,
   parameter int unsigned MEM_LAT = 3,
   parameter int unsigned CNT_W   = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   regwrite_scoreboard_if.slave  sb
);
   localparam int unsigned NREG = 8;

   typedef enum logic {ST_IDLE, ST_SPLIT} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q [NREG];
   logic [CNT_W-1:0] cnt_d [NREG];
   logic [NREG-1:0]  busy_c;
   logic             alu_haz_c, mem_haz_c, conflict_c;
   logic             alu_issue_c, mem_issue_c, stall_c;

   // Busy view of the countdowns; early release treats the writeback cycle as bypassable
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
`ifdef SCOREBOARD_EARLY_RELEASE_EN
         busy_c[r] = (cnt_q[r] > CNT_W'(1));
`else
         busy_c[r] = (cnt_q[r] != '0);
`endif
      end
   end

   assign alu_haz_c = busy_c[sb.alu_rn]
                    | (sb.alu_useRm    & busy_c[sb.alu_rm])
                    | (sb.alu_regWrite & busy_c[sb.alu_rd]);
   assign mem_haz_c = busy_c[sb.mem_rn]
                    | (sb.mem_useRd    & busy_c[sb.mem_rd])
                    | (sb.mem_regWrite & busy_c[sb.mem_rd]);
   assign conflict_c = sb.alu_regWrite & sb.mem_regWrite & (sb.alu_rd == sb.mem_rd);

   // Issue/split control
   always_comb begin
      state_d     = state_q;
      alu_issue_c = 1'b0;
      mem_issue_c = 1'b0;
      stall_c     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sb.bundle_valid && !sb.flush) begin
               if (alu_haz_c || mem_haz_c) begin
                  stall_c = 1'b1;
               end else if (conflict_c) begin
                  alu_issue_c = 1'b1;
                  stall_c     = 1'b1;
                  state_d     = ST_SPLIT;
               end else begin
                  alu_issue_c = 1'b1;
                  mem_issue_c = 1'b1;
               end
            end
         end
         ST_SPLIT: begin
            if (sb.flush) begin
               state_d = ST_IDLE;
            end else if (mem_haz_c) begin
               stall_c = 1'b1;
            end else begin
               mem_issue_c = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Countdown update; a new issue reloads the counter in place of decrementing
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - CNT_W'(1)) : cnt_q[r];
      end
      if (alu_issue_c && sb.alu_regWrite) cnt_d[sb.alu_rd] = CNT_W'(ALU_LAT);
      if (mem_issue_c && sb.mem_regWrite) cnt_d[sb.mem_rd] = CNT_W'(MEM_LAT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      end else begin
         state_q <= state_d;
         for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      end
   end

   // Outputs are quiet for the whole reset cycle regardless of decode inputs
   assign sb.alu_issue    = alu_issue_c & ~reset;
   assign sb.mem_issue    = mem_issue_c & ~reset;
   assign sb.stall        = stall_c & ~reset;
   assign sb.split_active = (state_q == ST_SPLIT) & ~reset;
   assign sb.busy_mask    = busy_c & {NREG{~reset}};
endmodule

// File: tb/tb_regwrite_scoreboard.sv
// Directed bench for regwrite_scoreboard: issue, RAW stall, same-rd split, flush, storeb, reset.
`timescale 1ns/1ps
module tb_regwrite_scoreboard;
`ifdef SCOREBOARD_EARLY_RELEASE_EN
   localparam int ER = 1;
`else
   localparam int ER = 0;
`endif
   localparam int ALU_LAT = 2;
   localparam int MEM_LAT = 3;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   regwrite_scoreboard_if sb_if();

   regwrite_scoreboard #(.ALU_LAT(ALU_LAT), .MEM_LAT(MEM_LAT), .CNT_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .sb    (sb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_o(input string tag, input logic ai, input logic mi, input logic st, input logic sa);
      chk({tag, ".alu_issue"},    32'(sb_if.alu_issue),    32'(ai));
      chk({tag, ".mem_issue"},    32'(sb_if.mem_issue),    32'(mi));
      chk({tag, ".stall"},        32'(sb_if.stall),        32'(st));
      chk({tag, ".split_active"}, 32'(sb_if.split_active), 32'(sa));
   endtask

   task automatic chk_busy(input string tag, input logic [7:0] exp);
      chk({tag, ".busy_mask"}, 32'(sb_if.busy_mask), 32'(exp));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic fl,
                        input logic awe, input logic aum, input logic [2:0] arm,
                        input logic [2:0] arn, input logic [2:0] ard,
                        input logic mwe, input logic mur, input logic [2:0] mrn,
                        input logic [2:0] mrd);
      sb_if.bundle_valid = v;   sb_if.flush     = fl;
      sb_if.alu_regWrite = awe; sb_if.alu_useRm = aum;
      sb_if.alu_rm = arm; sb_if.alu_rn = arn; sb_if.alu_rd = ard;
      sb_if.mem_regWrite = mwe; sb_if.mem_useRd = mur;
      sb_if.mem_rn = mrn; sb_if.mem_rd = mrd;
      #1;
   endtask

   task automatic idle_in();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0);
   endtask

   initial begin
      int s;
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      idle_in();
      tick();
      tick();

      // Outputs gated during reset even with a valid, hazard-free bundle
      drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd1, 1'b1, 1'b0, 3'd0, 3'd2);
      chk_o("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
      chk_busy("rst_hold", 8'h00);
      tick();
      reset = 1'b0;
      idle_in();
      chk_o("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
      chk_busy("post_rst", 8'h00);

      // Case 1: independent ALU write r3 + load r5 issue together
      drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd3, 1'b1, 1'b0, 3'd1, 3'd5);
      chk_o("c1_issue", 1'b1, 1'b1, 1'b0, 1'b0);
      tick();

      // Case 2: ALU reads r5 while the load is in flight
      drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd5, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0);
      chk_busy("c1_busy", 8'b0010_1000);
      s = MEM_LAT - ER;
      for (int k = 0; k <= s; k++) begin
         chk_o($sformatf("c2_k%0d", k), (k == s), (k == s), (k != s), 1'b0);
         if (k < s) tick();
      end
      tick();
      idle_in();
      chk_busy("c2_drained", 8'h00);

      // Case 3: same-rd bundle splits, MEM slot waits on the ALU write
      drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd2, 1'b1, 1'b0, 3'd0, 3'd2);
      chk_o("c3_alu", 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      s = ALU_LAT - ER;
      for (int k = 0; k <= s; k++) begin
         chk_o($sformatf("c3_k%0d", k), 1'b0, (k == s), (k != s), 1'b1);
         if (k < s) tick();
      end
      tick();
      idle_in();
      chk_o("c3_idle", 1'b0, 1'b0, 1'b0, 1'b0);
      chk_busy("c3_load", 8'h04);
      tick();
      tick();
      tick();
      chk_busy("c3_drained", 8'h00);

      // Case 4: flush during split; the ALU write keeps counting down
      drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd2, 1'b1, 1'b0, 3'd0, 3'd2);
      chk_o("c4_alu", 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk_o("c4_split", 1'b0, 1'b0, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 3'd2, 1'b1, 1'b0, 3'd0, 3'd2);
      chk_o("c4_flush", 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      idle_in();
      chk_o("c4_idle", 1'b0, 1'b0, 1'b0, 1'b0);
      chk_busy("c4_cnt1", (ER != 0) ? 8'h00 : 8'h04);
      tick();
      chk_busy("c4_cnt0", 8'h00);

      // Case 5: storeb reads r4 with one cycle of countdown left
      drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd4, 1'b0, 1'b0, 3'd0, 3'd0);
      chk_o("c5_wr", 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      idle_in();
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd0, 3'd4);
      s = 1 - ER;
      for (int k = 0; k <= s; k++) begin
         chk_o($sformatf("c5_k%0d", k), (k == s), (k == s), (k != s), 1'b0);
         if (k < s) tick();
      end
      tick();
      idle_in();
      chk_busy("c5_drained", 8'h00);

      // Case 6: reset while splitting with r6 in flight
      drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd6, 1'b1, 1'b0, 3'd0, 3'd6);
      chk_o("c6_alu", 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk_o("c6_split", 1'b0, 1'b0, 1'b1, 1'b1);
      chk_busy("c6_split", 8'h40);
      reset = 1'b1;
      #1;
      chk_o("c6_in_rst", 1'b0, 1'b0, 1'b0, 1'b0);
      chk_busy("c6_in_rst", 8'h00);
      tick();
      reset = 1'b0;
      idle_in();
      chk_o("c6_after", 1'b0, 1'b0, 1'b0, 1'b0);
      chk_busy("c6_after", 8'h00);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd6, 3'd6, 1'b0, 1'b0, 3'd0, 3'd0);
      chk_o("c6_fresh", 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      idle_in();
      chk_busy("c6_fresh", 8'h40);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
